// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared fixed-point math types and helpers
package math_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_Q_BITS         = 10;
  localparam int DEF_OUT_FIFO_DEPTH = 16;

  typedef logic signed [DEF_DATA_WIDTH-1:0] elem_t;
  typedef elem_t [2:0] vec3_t;

  // Drop the fractional bits of a double-width product/sum, flooring toward -inf.
  function automatic elem_t dequantize(input logic signed [2*DEF_DATA_WIDTH-1:0] s);
    return elem_t'(s >>> DEF_Q_BITS);
  endfunction

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module fifo #(
  parameter int FIFO_DATA_WIDTH  = 32,
  parameter int FIFO_BUFFER_SIZE = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0]            din,
  output logic                                  full,
  input  logic                                  rd_en,
  output logic [FIFO_DATA_WIDTH-1:0]            dout,
  output logic                                  empty,
  output logic [$clog2(FIFO_BUFFER_SIZE):0]     count
);

  localparam int AW = $clog2(FIFO_BUFFER_SIZE);
  localparam int CW = AW + 1;

  logic [FIFO_DATA_WIDTH-1:0] r_mem [FIFO_BUFFER_SIZE];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       w_do_wr;
  logic                       w_do_rd;

  assign empty   = (r_count == '0);
  assign full    = (r_count == CW'(FIFO_BUFFER_SIZE));
  assign count   = r_count;
  assign w_do_rd = rd_en && !empty;
  // A read frees the slot being written, so a full FIFO can still accept a write in the same cycle.
  assign w_do_wr = wr_en && (!full || w_do_rd);
  assign dout    = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_array.sv
// rtl/fifo_array.sv - lane-parallel vector FIFO with shared push/pop
module fifo_array #(
  parameter int ARRAY_SIZE       = 3,
  parameter int FIFO_DATA_WIDTH  = 32,
  parameter int FIFO_BUFFER_SIZE = 16
) (
  input  logic                                                  clock,
  input  logic                                                  reset,
  input  logic                                                  wr_en,
  input  logic [ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0]            din,
  output logic                                                  full,
  input  logic                                                  rd_en,
  output logic [ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0]            dout,
  output logic                                                  empty,
  output logic [ARRAY_SIZE-1:0][$clog2(FIFO_BUFFER_SIZE):0]     count
);

  logic [ARRAY_SIZE-1:0] w_full;
  logic [ARRAY_SIZE-1:0] w_empty;

  assign full  = |w_full;
  assign empty = |w_empty;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    fifo #(
      .FIFO_DATA_WIDTH  (FIFO_DATA_WIDTH),
      .FIFO_BUFFER_SIZE (FIFO_BUFFER_SIZE)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .wr_en (wr_en),
      .din   (din[g]),
      .full  (w_full[g]),
      .rd_en (rd_en),
      .dout  (dout[g]),
      .empty (w_empty[g]),
      .count (count[g])
    );
  end

endmodule

// File: rtl/dot_product.sv
// rtl/dot_product.sv - streaming fixed-point 3-element dot product with FWFT result buffer
module dot_product
  import math_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int Q_BITS         = DEF_Q_BITS,
  parameter int OUT_FIFO_DEPTH = DEF_OUT_FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0][DATA_WIDTH-1:0] x,
  input  logic [2:0][DATA_WIDTH-1:0] y,
  input  logic                       in_empty,
  output logic                       in_rd_en,
  output logic [DATA_WIDTH-1:0]      out,
  output logic                       out_empty,
  input  logic                       out_rd_en
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(OUT_FIFO_DEPTH) + 1;

  logic [2:0][PW-1:0]     w_prod;
  logic [2:0][PW-1:0]     r_prod;
  logic                   r_s1_valid;
  logic [PW-1:0]          w_sum;
  logic [DATA_WIDTH-1:0]  w_result;
  logic [DATA_WIDTH-1:0]  r_s2_data;
  logic                   r_s2_valid;
  logic [CW-1:0]          w_out_count;
  logic                   w_out_full;
  logic [CW:0]            w_occupancy;

  // Issue only when every result already buffered or in flight has a guaranteed slot.
  assign w_occupancy = {1'b0, w_out_count} + (CW+1)'(r_s1_valid) + (CW+1)'(r_s2_valid);
  assign in_rd_en    = !in_empty && !w_out_full && (w_occupancy < (CW+1)'(OUT_FIFO_DEPTH));

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < 3; i++) begin
      w_prod[i] = {{DATA_WIDTH{x[i][DATA_WIDTH-1]}}, x[i]} *
                  {{DATA_WIDTH{y[i][DATA_WIDTH-1]}}, y[i]};
    end
  end

  assign w_sum    = r_prod[0] + r_prod[1] + r_prod[2];
  assign w_result = DATA_WIDTH'($signed(w_sum) >>> Q_BITS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prod     <= '0;
      r_s1_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      if (in_rd_en) r_prod <= w_prod;
      r_s1_valid <= in_rd_en;
      r_s2_data  <= w_result;
      r_s2_valid <= r_s1_valid;
    end
  end

  fifo #(
    .FIFO_DATA_WIDTH  (DATA_WIDTH),
    .FIFO_BUFFER_SIZE (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (r_s2_valid),
    .din   (r_s2_data),
    .full  (w_out_full),
    .rd_en (out_rd_en),
    .dout  (out),
    .empty (out_empty),
    .count (w_out_count)
  );

endmodule

// File: tb/tb_dot_product.sv
// tb/tb_dot_product.sv - self-checking bench for dot_product fed by fifo_array sources
module tb_dot_product;
  import math_pkg::*;

  typedef struct {
    vec3_t       x;
    vec3_t       y;
    logic [31:0] exp;
  } vec_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  wr_en = 1'b0;
  vec3_t                 xd, yd;
  logic [2:0][31:0]      xq, yq;
  logic                  x_full, y_full, x_empty, y_empty;
  logic [2:0][5:0]       x_count, y_count;
  logic                  in_rd_en;
  logic [31:0]           out;
  logic                  out_empty;
  logic                  out_rd_en = 1'b0;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          pops = 0;
  int          first_pop = -1;
  int          last_pop = -1;
  logic [31:0] exp_q[$];
  vec_t        tbl[6];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  fifo_array #(.ARRAY_SIZE(3), .FIFO_DATA_WIDTH(32), .FIFO_BUFFER_SIZE(32)) u_xsrc (
    .clock(clock), .reset(reset), .wr_en(wr_en), .din(xd), .full(x_full),
    .rd_en(in_rd_en), .dout(xq), .empty(x_empty), .count(x_count));

  fifo_array #(.ARRAY_SIZE(3), .FIFO_DATA_WIDTH(32), .FIFO_BUFFER_SIZE(32)) u_ysrc (
    .clock(clock), .reset(reset), .wr_en(wr_en), .din(yd), .full(y_full),
    .rd_en(in_rd_en), .dout(yq), .empty(y_empty), .count(y_count));

  dot_product u_dut (
    .clock(clock), .reset(reset), .x(xq), .y(yq), .in_empty(x_empty | y_empty),
    .in_rd_en(in_rd_en), .out(out), .out_empty(out_empty), .out_rd_en(out_rd_en));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted pop is compared against the oldest expected result.
  always @(negedge clock) begin
    if (reset && out_rd_en && !out_empty) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (exp_q.size() == 0) check("unexpected_result", out, 64'hdead);
      else check("result", out, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] model(input vec3_t a, input vec3_t b);
    longint s = 0;
    for (int i = 0; i < 3; i++) s += longint'(a[i]) * longint'(b[i]);
    return 32'(s >>> 10);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input vec3_t xv, input vec3_t yv, input logic [31:0] e);
    wr_en = 1'b1;
    xd = xv;
    yd = yv;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic single(input vec3_t xv, input vec3_t yv, input logic [31:0] e);
    int lat;
    push(xv, yv, e);
    wr_en = 1'b0;
    @(negedge clock);
    check("issue", in_rd_en, 1);
    @(posedge clock);
    #1;
    lat = 0;
    while (out_empty && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", lat, 2);
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      tick();
      n++;
    end
    check(nm, exp_q.size(), 0);
  endtask

  function automatic vec3_t rand_vec();
    vec3_t v;
    int    t;
    for (int i = 0; i < 3; i++) begin
      t = $urandom_range(0, 16383) - 8192;
      v[i] = ($urandom_range(0, 1) == 1) ? elem_t'($urandom) : elem_t'(t);
    end
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec3_t a, b;

    tbl[0] = '{x: {32'h0C00, 32'h0800, 32'h0400}, y: {32'h1800, 32'h1400, 32'h1000}, exp: 32'h0000_8000};
    tbl[1] = '{x: {32'h0, 32'h0, 32'hFFFF_FA00}, y: {32'h0, 32'h0, 32'h0800}, exp: 32'hFFFF_F400};
    tbl[2] = '{x: {32'h0, 32'h0, 32'hFFFF_FE00}, y: {32'h0, 32'h0, 32'h1}, exp: 32'hFFFF_FFFF};
    tbl[3] = '{x: {32'h0, 32'h0400, 32'hFFFF_FC00}, y: {32'h07FF, 32'h0400, 32'h0400}, exp: 32'h0};
    tbl[4] = '{x: {32'h0, 32'h0, 32'h0200}, y: {32'h0, 32'h0, 32'h0200}, exp: 32'h0000_0100};
    tbl[5] = '{x: {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
               y: {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, exp: 32'hFF40_0000};

    #3;
    check("reset_out_empty", out_empty, 1);
    check("reset_in_rd_en", in_rd_en, 0);
    check("reset_out", out, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) single(tbl[i].x, tbl[i].y, tbl[i].exp);
    check("table_drained", exp_q.size(), 0);

    // Streaming with the consumer always ready.
    out_rd_en = 1'b1;
    pops = 0;
    first_pop = -1;
    for (int i = 0; i < 100; i++) begin
      a = rand_vec();
      b = rand_vec();
      push(a, b, model(a, b));
    end
    wr_en = 1'b0;
    drain("stream_drain");
    check("stream_count", pops, 100);
    check("stream_rate", last_pop - first_pop, 99);
    out_rd_en = 1'b0;
    tick();

    // Backpressure: consumer stalled until the output buffer fills.
    for (int i = 0; i < 20; i++) begin
      a = rand_vec();
      b = rand_vec();
      push(a, b, model(a, b));
    end
    wr_en = 1'b0;
    repeat (40) tick();
    check("bp_out_empty", out_empty, 0);
    check("bp_in_rd_en", in_rd_en, 0);
    check("bp_src_left", x_count[0], 4);
    pops = 0;
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    check("bp_reissue", in_rd_en, 1);
    out_rd_en = 1'b1;
    drain("bp_drain");
    check("bp_count", pops, 20);
    out_rd_en = 1'b0;
    tick();

    // Reset with 3 results buffered and 2 in flight.
    for (int i = 0; i < 5; i++) begin
      a = rand_vec();
      b = rand_vec();
      push(a, b, model(a, b));
    end
    wr_en = 1'b0;
    tick();
    check("pre_reset_buffered", out_empty, 0);
    reset = 1'b0;
    #1;
    check("mid_reset_out_empty", out_empty, 1);
    check("mid_reset_in_rd_en", in_rd_en, 0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
    single(tbl[0].x, tbl[0].y, tbl[0].exp);
    repeat (3) tick();
    check("post_reset_empty", out_empty, 1);
    check("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dot_product.md
# dot_product

Streaming fixed-point 3-element dot-product engine for the ray-tracer math pipeline. It pops one pair of signed Q-format vectors (x, y) per cycle from upstream vector FIFOs (fifo_array instances, one per operand), computes x·y in a 2-stage pipeline and pushes each scalar result into an internal output FIFO. Downstream blocks read that FIFO through a first-word-fall-through empty/rd_en handshake.

## Interface
- DATA_WIDTH, 32: width of every vector element and of the result, two's complement.
- Q_BITS, 10: number of fractional bits (Q21.10 by default).
- OUT_FIFO_DEPTH, 16: output FIFO depth in words; must be a power of two and at least 4.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Port names are reset and clock.
- x  in  3×DATA_WIDTH  operand vector x[2:0]. Valid whenever in_empty is 0 (FWFT).
- y  in  3×DATA_WIDTH  operand vector y[2:0]. Valid whenever in_empty is 0.
- in_empty  in  1  high when no input pair is available (OR of both source FIFOs' empty flags).
- in_rd_en  out  1  pops one pair from both source FIFOs on this clock edge.
- out  out  DATA_WIDTH  head of the output FIFO. Valid when out_empty is 0.
- out_empty  out  1  output FIFO empty.
- out_rd_en  in  1  pops the output FIFO head on this clock edge. Ignored when out_empty is 1.

## Operation
- Products: p_i = x_i * y_i, full 2·DATA_WIDTH signed.
- Sum: s = p0 + p1 + p2, 2·DATA_WIDTH signed; wrap on overflow.
- Result: out = s >>> Q_BITS (arithmetic shift, so it floors toward −∞), truncated to the low DATA_WIDTH bits. There is no saturation or rounding.
- Issue rule: in_rd_en = !in_empty && (fifo_count + in_flight) < OUT_FIFO_DEPTH.
  - in_flight counts valid stages in the pipeline.
  - This guarantees no result is ever dropped and no pipeline stall is needed.
- Pipeline:
  - S1 registers the three products and a valid bit, captured when in_rd_en is 1.
  - S2 registers the shifted sum and a valid bit.
  - The output FIFO write enable is the S2 valid bit.
- The output FIFO accepts a simultaneous write and read when not empty. Count stays unchanged and data order is preserved.
- Results leave in strict input order.

## Timing
- Reset (reset = 0, asynchronous): S1/S2 valid bits clear, FIFO pointers and count cleared, out_empty = 1, in_rd_en = 0, out = 0.
- Latency: in_rd_en high at edge N → result written at edge N+2 → out_empty = 0 after edge N+2, visible in cycle N+2.
- Throughput: one result per clock while the input is non-empty and the consumer keeps up.
- Full output FIFO: in_rd_en drops while count + in_flight = OUT_FIFO_DEPTH. It reasserts the cycle after an out_rd_en frees a slot.
- Empty input: no pop; pipeline bubbles propagate with valid = 0.
- out_rd_en while out_empty = 1: no effect. Pointers wrap modulo OUT_FIFO_DEPTH.
- Reset mid-operation discards in-flight and buffered results. No pop occurs on the reset edge.

## Structure
- Shared package (math_pkg): DATA_WIDTH, Q_BITS defaults, a vec3_t typedef (array [2:0] of logic signed [DATA_WIDTH-1:0]) and a dequantize function for a 2·DATA_WIDTH signed value.
- Sub-module fifo: synchronous FWFT FIFO with parameters FIFO_DATA_WIDTH and FIFO_BUFFER_SIZE, ports wr_en/din/full/rd_en/dout/empty, and a count output. It is instantiated once as the output buffer.
- The same fifo is replicated ARRAY_SIZE times in fifo_array, the shared vector FIFO that feeds x and y. fifo_array shares wr_en and rd_en across lanes; full is the OR of lane full flags and empty is the OR of lane empty flags.

## Test plan
- Basic: x = (0x400, 0x800, 0xC00), y = (0x1000, 0x1400, 0x1800), i.e. 1,2,3 · 4,5,6 → out = 0x00008000 (32.0), out_empty falls 2 cycles after pop.
- Negative: x = (0xFFFFFA00, 0, 0), y = (0x800, 0, 0) → 0xFFFFF400 (−3.0). Floor: x = (0xFFFFFE00, 0, 0), y = (1, 0, 0) → 0xFFFFFFFF.
- Streaming: 100 random vector pairs written back-to-back, out_rd_en held high → 100 results in order matching the software model, one per cycle after the 2-cycle fill.
- Backpressure: 20 pairs queued, out_rd_en held low → exactly 16 results buffered, in_rd_en low, then all 20 drained in order with no loss or duplicates.
- Reset mid-stream: assert reset with 3 results buffered and 2 in flight → out_empty = 1 immediately, and the next input produces the correct result 2 cycles after its pop.
